// File: rtl/bm_case_pipe.sv
// Two-stage valid/ready logic pipeline: S1 registers operands, S2 registers result/zero flag/~A.
// Optional parity output enabled by defining BM_CASE_PARITY_EN.
module bm_case_pipe #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out1,
    output logic [WIDTH-1:0] out2,
    output logic [CNT_W-1:0] zero_cnt
`ifdef BM_CASE_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [WIDTH-1:0] op_result(input logic [1:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return '0;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic             out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
`ifdef BM_CASE_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] s2_res;

    // S2 can take a new result when it is empty or draining this cycle.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;
    assign s2_res   = op_result(s1_op_q, s1_a_q, s1_b_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a_in;
            s1_b_d     = b_in;
            s1_op_d    = op_in;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        zero_cnt_d = zero_cnt_q;
`ifdef BM_CASE_PARITY_EN
        parity_d   = parity_q;
`endif
        if (out_fire) begin
            s2_valid_d = 1'b0;
            if (out1_q) begin
                zero_cnt_d = sat_inc(zero_cnt_q);
            end
        end
        // Advance overrides the drain so a full pipe moves in lock-step.
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            out0_d     = s2_res;
            out1_d     = (s2_res == '0);
            out2_d     = ~s1_a_q;
`ifdef BM_CASE_PARITY_EN
            parity_d   = ^s2_res;
`endif
        end
    end

    // Stage S1 boundary: operand registers carry no reset, only their valid does.
    always_ff @(posedge clock) begin
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s1_op_q <= s1_op_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Stage S2 boundary: result registers and zero-hit counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            out0_q     <= '0;
            out1_q     <= 1'b0;
            out2_q     <= '0;
            zero_cnt_q <= '0;
`ifdef BM_CASE_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            s2_valid_q <= s2_valid_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            zero_cnt_q <= zero_cnt_d;
`ifdef BM_CASE_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign zero_cnt  = zero_cnt_q;
`ifdef BM_CASE_PARITY_EN
    assign parity    = parity_q;
`endif

endmodule

// File: doc/bm_case_pipe.md
BM_CASE_PIPE -- requirements
Module: bm_case_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the zero-hit counter width in bits.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers a_in/b_in/op_in this cycle.
REQ-006 in_ready  output  1  block accepts this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 op_in  input  2  operation select.
REQ-010 out_valid  output  1  out0/out1/out2 hold a valid result.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-012 out0  output  WIDTH  operation result.
REQ-013 out1  output  1  zero flag; 1 when out0 == 0.
REQ-014 out2  output  WIDTH  bitwise complement of the accepted a_in.
REQ-015 zero_cnt  output  CNT_W  saturating count of output transfers with out1 == 1.
REQ-016 parity  output  1  XOR-reduction of out0; present only with BM_CASE_PARITY_EN.

Function
REQ-017 The op_in decode SHALL be: 2'b00 -> all zeros; 2'b01 -> a_in & b_in; 2'b10 -> a_in | b_in; 2'b11 -> a_in ^ b_in.
REQ-018 The datapath SHALL be a two-stage registered pipeline: stage S1 (operands, op) and stage S2 (out0, out1, out2).
REQ-019 Accept-to-out_valid latency SHALL be exactly 2 clock cycles when downstream never stalls.
REQ-020 With out_ready held high, the block SHALL sustain one transfer per cycle.
REQ-021 in_ready SHALL equal !S1_valid || !S2_valid || out_ready, and MAY depend combinationally on out_ready.
REQ-022 While out_valid && !out_ready, out0, out1, out2 and parity SHALL hold stable.
REQ-023 When full (both stages valid) and out_ready is low, in_ready SHALL be 0 and no input SHALL be lost or overwritten.
REQ-024 When full and out_ready is high, the output drain, the S1->S2 advance and the new input capture SHALL all occur in the same cycle.
REQ-025 A bubble in S2 SHALL be filled from S1 regardless of out_ready.
REQ-026 When S1 is empty, the S1 capture SHALL depend only on in_valid.
REQ-027 zero_cnt SHALL increment by 1 on each output transfer with out1 == 1.
REQ-028 zero_cnt SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-029 Outputs SHALL be in-order; there SHALL be no reordering or duplication of results.

Reset
REQ-030 Assertion of reset_n low SHALL immediately clear S1_valid, S2_valid, out0, out1, out2, zero_cnt and parity to 0, independent of clock.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight data; no result from before reset SHALL appear after it.
REQ-032 On the first rising edge after reset_n deasserts, in_ready SHALL be 1.
REQ-033 On the first rising edge after reset_n deasserts, out_valid SHALL be 0.

Configuration
REQ-034 With macro BM_CASE_PARITY_EN defined, the parity port SHALL exist, be registered in S2 alongside out0, and equal ^out0.
REQ-035 Without BM_CASE_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-036 Reset, then a_in=2'b11, b_in=2'b10, op=01 for one cycle, out_ready=1 -> out_valid two cycles later with out0=2'b10, out1=0, out2=2'b00.
REQ-037 Back-to-back ops 00/01/10/11 with a=2'b01, b=2'b11 -> out0 sequence 00, 01, 11, 10 on consecutive cycles; zero_cnt ends at 1.
REQ-038 out_ready=0 while 3 inputs are offered -> 2 accepted, then in_ready=0; outputs stable; on release, results drain in order with none lost.
REQ-039 CNT_W=2, send 5 op=00 transfers -> zero_cnt reads 3 after the 3rd transfer and stays 3.
REQ-040 Assert reset_n low asynchronously mid-stream with the pipeline full -> out_valid=0 and zero_cnt=0 immediately; no stale result after release.
REQ-041 Build with BM_CASE_PARITY_EN, WIDTH=8, a=8'hF0, b=8'h13, op=11 -> out0=8'hE3, parity=1.
